// File: rtl/fpga_e_pkg.sv
// Shared constants and FSM state type for the exponent bit streamer.
package fpga_e_pkg;

  localparam int unsigned REGISTER_SIZE = 32;
  localparam int unsigned BITS_IN_N     = 2048;

  typedef enum logic [1:0] {
    LOAD,
    PRIME,
    SERVE
  } state_e;

endpackage

// File: rtl/exponent_bit_streamer_ram.sv
// Block RAM with registered output (2-cycle read latency), read-first on port A.
// Port B is kept read-only so the array has a single write process.
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned RAM_DEPTH = 64
) (
  input  logic                         clka,
  input  logic                         ena,
  input  logic                         wea,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  output logic [RAM_WIDTH-1:0]         douta,
  input  logic                         clkb,
  input  logic                         enb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_a_q;
  logic [RAM_WIDTH-1:0] ram_b_q;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_a_q <= mem[addra];
    end
    douta <= ram_a_q;
  end

  always_ff @(posedge clkb) begin
    if (enb) ram_b_q <= mem[addrb];
    doutb <= ram_b_q;
  end

endmodule

// File: rtl/exponent_bit_streamer.sv
// Stores the exponent N in block RAM and replays it LSB first, one bit per
// consume pulse, wrapping after BITS_IN_N bits.
module exponent_bit_streamer #(
  parameter int unsigned REGISTER_SIZE = fpga_e_pkg::REGISTER_SIZE,
  parameter int unsigned BITS_IN_N     = fpga_e_pkg::BITS_IN_N
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         load_valid_in,
  input  logic [REGISTER_SIZE-1:0]     load_block_in,
  output logic                         load_ready_out,
  input  logic                         flush_in,
  input  logic                         consumed_n_in,
  output logic                         n_bit_out,
  output logic                         bit_valid_out,
  output logic [$clog2(BITS_IN_N)-1:0] bit_idx_out,
  output logic                         last_bit_out,
  output logic                         pass_done_out
);

  import fpga_e_pkg::*;

  localparam int unsigned WORDS = BITS_IN_N / REGISTER_SIZE;
  localparam int unsigned AW    = $clog2(WORDS);
  localparam int unsigned IW    = $clog2(BITS_IN_N);
  localparam int unsigned OW    = $clog2(REGISTER_SIZE);

  state_e                   state_q, state_d;
  logic [AW-1:0]            load_ptr_q, load_ptr_d;
  logic [1:0]               prime_cnt_q, prime_cnt_d;
  logic [IW-1:0]            bit_idx_q, bit_idx_d;
  logic [REGISTER_SIZE-1:0] shift_q, shift_d;
  logic [REGISTER_SIZE-1:0] pref_q, pref_d;
  logic                     pass_done_q, pass_done_d;
  logic                     rd_s1_q, rd_s1_d, rd_s2_q;
  logic                     dst1_q, dst1_d, dst2_q;

  logic                     ram_we;
  logic [AW-1:0]            ram_addr;
  logic [REGISTER_SIZE-1:0] ram_dout;
  logic [REGISTER_SIZE-1:0] unused_doutb;
  logic [AW:0]              next_word;

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH(REGISTER_SIZE),
    .RAM_DEPTH(WORDS)
  ) u_ram (
    .clka (clk_in),
    .ena  (1'b1),
    .wea  (ram_we),
    .addra(ram_addr),
    .dina (load_block_in),
    .douta(ram_dout),
    .clkb (clk_in),
    .enb  (1'b0),
    .addrb('0),
    .doutb(unused_doutb)
  );

  // Word two ahead of the one being shifted out, modulo WORDS.
  always_comb begin
    next_word = {1'b0, bit_idx_q[OW +: AW]} + (AW+1)'(2);
    if (next_word >= (AW+1)'(WORDS)) next_word = next_word - (AW+1)'(WORDS);
  end

  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    prime_cnt_d = prime_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    pref_d      = pref_q;
    pass_done_d = 1'b0;
    rd_s1_d     = 1'b0;
    dst1_d      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = load_ptr_q;

    // Read data lands two cycles after issue; the tag says which register it fills.
    if (rd_s2_q) begin
      if (dst2_q) pref_d = ram_dout;
      else        shift_d = ram_dout;
    end

    unique case (state_q)
      LOAD: begin
        if (load_valid_in) begin
          ram_we     = 1'b1;
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_ptr_q == AW'(WORDS-1)) begin
            state_d     = PRIME;
            prime_cnt_d = '0;
            load_ptr_d  = '0;
          end
        end
      end
      PRIME: begin
        ram_addr    = AW'(prime_cnt_q);
        rd_s1_d     = (prime_cnt_q < 2'd2);
        dst1_d      = prime_cnt_q[0];
        prime_cnt_d = prime_cnt_q + 1'b1;
        if (prime_cnt_q == 2'd2) state_d = SERVE;
      end
      SERVE: begin
        ram_addr = next_word[AW-1:0];
        if (flush_in) begin
          state_d     = PRIME;
          prime_cnt_d = '0;
          bit_idx_d   = '0;
        end else if (consumed_n_in) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IW'(BITS_IN_N-1)) begin
            bit_idx_d   = '0;
            pass_done_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
          if (&bit_idx_q[OW-1:0]) begin
            shift_d = pref_q;
            rd_s1_d = 1'b1;
            dst1_d  = 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= LOAD;
      load_ptr_q  <= '0;
      prime_cnt_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      pref_q      <= '0;
      pass_done_q <= 1'b0;
      rd_s1_q     <= 1'b0;
      rd_s2_q     <= 1'b0;
      dst1_q      <= 1'b0;
      dst2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      prime_cnt_q <= prime_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      pref_q      <= pref_d;
      pass_done_q <= pass_done_d;
      rd_s1_q     <= rd_s1_d;
      rd_s2_q     <= rd_s1_q;
      dst1_q      <= dst1_d;
      dst2_q      <= dst1_q;
    end
  end

  assign load_ready_out = (state_q == LOAD);
  assign bit_valid_out  = (state_q == SERVE);
  assign n_bit_out      = bit_valid_out & shift_q[0];
  assign bit_idx_out    = bit_idx_q;
  assign last_bit_out   = bit_valid_out && (bit_idx_q == IW'(BITS_IN_N-1));
  assign pass_done_out  = pass_done_q;

endmodule

// File: tb/tb_exponent_bit_streamer.sv
// Randomized bench for exponent_bit_streamer against a cycle-count level model of N replay.
module tb_exponent_bit_streamer;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        load_valid_in;
  logic [31:0] load_block_in;
  logic        load_ready_out;
  logic        flush_in;
  logic        consumed_n_in;
  logic        n_bit_out;
  logic        bit_valid_out;
  logic [10:0] bit_idx_out;
  logic        last_bit_out;
  logic        pass_done_out;

  exponent_bit_streamer dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n_in),
    .load_valid_in (load_valid_in),
    .load_block_in (load_block_in),
    .load_ready_out(load_ready_out),
    .flush_in      (flush_in),
    .consumed_n_in (consumed_n_in),
    .n_bit_out     (n_bit_out),
    .bit_valid_out (bit_valid_out),
    .bit_idx_out   (bit_idx_out),
    .last_bit_out  (last_bit_out),
    .pass_done_out (pass_done_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: N as 64 words, a cursor, and the cycle at which bits become valid.
  logic [31:0] m_words [64];
  int          m_ld = 0;
  int          m_idx = 0;
  int          m_cyc = 0;
  int          m_valid_at = 0;
  bit          m_pd = 0;

  always @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_ld = 0; m_idx = 0; m_valid_at = 0; m_pd = 0;
    end else begin
      m_pd = 0;
      if (m_ld < 64) begin
        if (load_valid_in) begin
          m_words[m_ld] = load_block_in;
          m_ld++;
          if (m_ld == 64) begin
            m_valid_at = m_cyc + 4;
            m_idx = 0;
          end
        end
      end else if (m_cyc >= m_valid_at) begin
        if (flush_in) begin
          m_valid_at = m_cyc + 4;
          m_idx = 0;
        end else if (consumed_n_in) begin
          if (m_idx == 2047) m_pd = 1;
          m_idx = (m_idx + 1) % 2048;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n_in) begin
      bit exp_valid;
      exp_valid = (m_ld == 64) && (m_cyc >= m_valid_at);
      check("load_ready", load_ready_out, 32'(m_ld < 64));
      check("bit_valid", bit_valid_out, 32'(exp_valid));
      check("pass_done", pass_done_out, 32'(m_pd));
      check("last_bit", last_bit_out, 32'(exp_valid && m_idx == 2047));
      if (exp_valid) begin
        check("bit_idx", bit_idx_out, 32'(m_idx));
        check("n_bit", n_bit_out, 32'(m_words[m_idx / 32][m_idx % 32]));
      end
    end
  end

  logic [31:0] ld_words [64];
  bit          got[$];
  int          pd_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; load_valid_in = 1'b0; load_block_in = '0;
    flush_in = 1'b0; consumed_n_in = 1'b0;
    tick(); tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic load_n();
    int i = 0;
    int guard = 0;
    while (i < 64 && guard < 1000) begin
      bit acc;
      load_valid_in = ($urandom_range(3, 0) != 0);
      load_block_in = load_valid_in ? ld_words[i] : $urandom();
      acc = load_valid_in && load_ready_out;
      tick();
      load_valid_in = 1'b0;
      if (acc) i++;
      guard++;
    end
    check("load_accepts", i, 64);
  endtask

  task automatic wait_valid(string name);
    int k = 0;
    while (!bit_valid_out && k < 20) begin
      tick();
      k++;
    end
    check(name, k, 3);
  endtask

  task automatic consume(int n, int gap_lo, int gap_hi);
    for (int i = 0; i < n; i++) begin
      int g;
      check("consume_valid", bit_valid_out, 1);
      if (bit_idx_out == 11'd2047) check("last_at_2047", last_bit_out, 1);
      got.push_back(n_bit_out);
      consumed_n_in = 1'b1;
      tick();
      consumed_n_in = 1'b0;
      if (pass_done_out) pd_cnt++;
      g = $urandom_range(gap_hi, gap_lo);
      repeat (g) begin
        tick();
        if (pass_done_out) pd_cnt++;
      end
    end
  endtask

  initial begin
    int ones;
    logic [31:0] wv;
    logic [31:0] r;
    bit exp_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    // Reset values
    do_reset();
    check("rst_load_ready", load_ready_out, 1);
    check("rst_bit_valid", bit_valid_out, 0);
    check("rst_n_bit", n_bit_out, 0);
    check("rst_last_bit", last_bit_out, 0);
    check("rst_pass_done", pass_done_out, 0);

    // N = 0x8000...0001
    foreach (ld_words[w]) ld_words[w] = '0;
    ld_words[0]  = 32'h0000_0001;
    ld_words[63] = 32'h8000_0000;
    load_n();
    wait_valid("prime_latency");
    check("first_idx", bit_idx_out, 0);
    got.delete();
    pd_cnt = 0;
    consume(2048, 0, 2);
    ones = 0;
    foreach (got[i]) ones += int'(got[i]);
    check("a_bit0", got[0], 1);
    check("a_bit2047", got[2047], 1);
    check("a_popcount", ones, 2);
    check("a_pass_done_cnt", pd_cnt, 1);

    // Async reset in the middle of a pass
    consume(777, 0, 2);
    check("idx_777", bit_idx_out, 777);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("arst_load_ready", load_ready_out, 1);
    check("arst_bit_valid", bit_valid_out, 0);
    check("arst_bit_idx", bit_idx_out, 0);
    check("arst_n_bit", n_bit_out, 0);
    check("arst_last_bit", last_bit_out, 0);
    check("arst_pass_done", pass_done_out, 0);
    tick();
    rst_n_in = 1'b1;
    consumed_n_in = 1'b1;
    repeat (5) begin
      tick();
      check("post_rst_valid", bit_valid_out, 0);
    end
    consumed_n_in = 1'b0;

    // word w = w * 0x01010101, back-to-back consumes
    foreach (ld_words[w]) ld_words[w] = 32'(w) * 32'h0101_0101;
    load_n();
    wait_valid("prime_latency_b");
    got.delete();
    consume(2048, 0, 0);
    for (int w = 0; w < 64; w++) begin
      for (int b = 0; b < 32; b++) wv[b] = got[w*32 + b];
      check("word_recon", wv, 32'(w) * 32'h0101_0101);
    end
    check("b_idx_wrapped", bit_idx_out, 0);

    // Sparse consumes, accumulator-like spacing
    got.delete();
    consume(300, 129, 129);
    check("sparse_idx", bit_idx_out, 300);
    for (int i = 0; i < 300; i++) begin
      wv = 32'(i / 32) * 32'h0101_0101;
      check("sparse_bit", got[i], wv[i % 32]);
    end

    // Flush with simultaneous consume, then wrap with 0xA5 in the low byte
    do_reset();
    foreach (ld_words[w]) ld_words[w] = $urandom();
    r = $urandom();
    ld_words[0] = {r[31:8], 8'hA5};
    load_n();
    wait_valid("prime_latency_c");
    consume(100, 0, 3);
    check("pre_flush_idx", bit_idx_out, 100);
    flush_in = 1'b1;
    consumed_n_in = 1'b1;
    tick();
    flush_in = 1'b0;
    consumed_n_in = 1'b0;
    check("flush_drop_valid", bit_valid_out, 0);
    wait_valid("flush_latency");
    check("flush_idx", bit_idx_out, 0);
    check("flush_bit0", n_bit_out, 1);
    got.delete();
    pd_cnt = 0;
    consume(2048 + 40, 0, 0);
    check("wrap_pass_done_cnt", pd_cnt, 1);
    check("wrap_idx", bit_idx_out, 40);
    for (int i = 0; i < 8; i++) begin
      check("wrap_first_pass", got[i], exp_seq[i]);
      check("wrap_repeat", got[2048 + i], exp_seq[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
